// File: rtl/interrupt_collector_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the interrupt collector:
//   intr_state_e  : aggregation FSM states (IDLE, ASSERT, HOLDOFF)
//   C_MAX_HOLDOFF : largest hold-off count the 8-bit counter can hold
//   id_width()    : width of the irq_id field, max(1, clog2(w))
// -----------------------------------------------------------------------------
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } intr_state_e;

    localparam int C_MAX_HOLDOFF = 255;

    function automatic int id_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/interrupt_collector_if.sv
// -----------------------------------------------------------------------------
// interrupt_collector_if
// Acknowledge handshake between a host agent (master) and the collector
// (slave).
//   ack_valid : master requests clearing of the bits in ack_mask
//   ack_mask  : pending bits to clear, held stable until accepted
//   ack_ready : collector can accept an acknowledge this cycle
// -----------------------------------------------------------------------------
interface interrupt_collector_if #(
    parameter int W = 1
);
    logic         ack_valid;
    logic [W-1:0] ack_mask;
    logic         ack_ready;

    modport master (
        output ack_valid,
        output ack_mask,
        input  ack_ready
    );

    modport slave (
        input  ack_valid,
        input  ack_mask,
        output ack_ready
    );
endinterface

// File: rtl/interrupt_collector_sync_edge.sv
// -----------------------------------------------------------------------------
// intr_sync_edge
// One interrupt line: optional synchronizer chain followed by set-pulse
// generation (rising edge or level).
//   clk    : clock
//   srst   : synchronous active-high reset (clears sync chain and history)
//   line_i : raw interrupt line
//   set_o  : request to set the pending bit this cycle
// -----------------------------------------------------------------------------
module intr_sync_edge #(
    parameter int C_SYNC_STAGES = 2,
    parameter bit C_EDGE        = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic line_i,
    output logic set_o
);

    logic s_sync;

    generate
        if (C_SYNC_STAGES == 0) begin : g_nosync
            // Line is already in the clk domain.
            assign s_sync = line_i;
        end else begin : g_sync
            logic [C_SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (srst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= line_i;
                    for (int i = 1; i < C_SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s_sync = sync_q[C_SYNC_STAGES-1];
        end
    endgenerate

    generate
        if (C_EDGE) begin : g_edge
            // History resets to 0 so a line held high across reset fires again.
            logic prev_q;

            always_ff @(posedge clk) begin
                if (srst) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= s_sync;
                end
            end

            assign set_o = s_sync & ~prev_q;
        end else begin : g_level
            assign set_o = s_sync;
        end
    endgenerate

endmodule

// File: rtl/interrupt_collector.sv
// -----------------------------------------------------------------------------
// interrupt_collector
// Latches a bundle of interrupt lines into sticky pending bits, masks them
// with a per-bit enable and drives one registered irq plus the lowest pending
// enabled index. Pending bits are cleared through a valid/ready acknowledge;
// after an acknowledge of a raised irq the output is held low (and further
// acknowledges are refused) for C_HOLDOFF cycles so a level source has time
// to drop.
//   aclk        : clock
//   areset      : synchronous active-high reset
//   s_interrupt : interrupt lines
//   irq_enable  : per-bit enable for irq aggregation
//   ack_if      : acknowledge handshake (slave side)
//   pending     : sticky pending status
//   irq         : aggregated interrupt
//   irq_id      : lowest index set in pending & irq_enable, 0 when none
// -----------------------------------------------------------------------------
module interrupt_collector
    import intr_pkg::*;
#(
    parameter int          C_INTERRUPT_WIDTH = 1,
    parameter logic [31:0] C_EDGE_MASK       = 32'h0,
    parameter int          C_SYNC_STAGES     = 2,
    parameter int          C_HOLDOFF         = 4
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [C_INTERRUPT_WIDTH-1:0]           s_interrupt,
    input  logic [C_INTERRUPT_WIDTH-1:0]           irq_enable,
    interrupt_collector_if.slave                   ack_if,
    output logic [C_INTERRUPT_WIDTH-1:0]           pending,
    output logic                                   irq,
    output logic [id_width(C_INTERRUPT_WIDTH)-1:0] irq_id
);

    localparam int W    = C_INTERRUPT_WIDTH;
    localparam int ID_W = id_width(C_INTERRUPT_WIDTH);
    localparam int HOLDOFF_CLAMP = (C_HOLDOFF > C_MAX_HOLDOFF) ? C_MAX_HOLDOFF : C_HOLDOFF;
    localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CLAMP);

    logic [W-1:0] set_vec;
    logic [W-1:0] act;
    logic         ack_fire;

    logic [W-1:0] pending_q, pending_d;
    intr_state_e  state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         irq_q, irq_d;
    logic         ack_ready_q, ack_ready_d;

    // Per-line synchronizer and set generation.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_line
            intr_sync_edge #(
                .C_SYNC_STAGES (C_SYNC_STAGES),
                .C_EDGE        (C_EDGE_MASK[gi])
            ) u_sync_edge (
                .clk    (aclk),
                .srst   (areset),
                .line_i (s_interrupt[gi]),
                .set_o  (set_vec[gi])
            );
        end
    endgenerate

    assign ack_fire = ack_if.ack_valid & ack_ready_q;
    assign act      = pending_q & irq_enable;

    // Set is ORed in after the clear so an event landing on an acknowledged
    // bit in the same cycle is never lost.
    always_comb begin
        pending_d = pending_q | set_vec;
        if (ack_fire) begin
            pending_d = (pending_q & ~ack_if.ack_mask) | set_vec;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // An ack taken here (polling mode) clears bits but starts no hold-off.
                if (act != '0) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_fire) begin
                    if (HOLDOFF_LOAD == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        cnt_d   = HOLDOFF_LOAD;
                    end
                end else if (act == '0) begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (cnt_q <= 8'd1) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // Outputs are registered copies of what the next state implies.
        irq_d       = (state_d == ASSERT);
        ack_ready_d = (state_d != HOLDOFF);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pending_q   <= '0;
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            irq_q       <= 1'b0;
            ack_ready_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            irq_q       <= irq_d;
            ack_ready_q <= ack_ready_d;
        end
    end

    // Priority encoder, registered alongside irq; updates in every state.
    generate
        if (W == 1) begin : g_id_const
            assign irq_id = '0;
        end else begin : g_id_enc
            logic [ID_W-1:0] irq_id_q, irq_id_d;

            always_comb begin
                irq_id_d = '0;
                // Scan downward so the lowest set index wins.
                for (int i = W - 1; i >= 0; i--) begin
                    if (act[i]) begin
                        irq_id_d = ID_W'(i);
                    end
                end
            end

            always_ff @(posedge aclk) begin
                if (areset) begin
                    irq_id_q <= '0;
                end else begin
                    irq_id_q <= irq_id_d;
                end
            end

            assign irq_id = irq_id_q;
        end
    endgenerate

    assign pending          = pending_q;
    assign irq              = irq_q;
    assign ack_if.ack_ready = ack_ready_q;

endmodule

// File: tb/tb_interrupt_collector.sv
// -----------------------------------------------------------------------------
// tb_interrupt_collector
// Directed scenarios plus a randomized run for interrupt_collector
// (4 lines, bit0 edge-sensitive, 2 sync stages, hold-off 4). A behavioural
// model advances once per clock inside step() and supplies the expected
// outputs for the randomized run.
// -----------------------------------------------------------------------------
module tb_interrupt_collector;

    localparam int         W      = 4;
    localparam int         ID_W   = 2;
    localparam int         SYNC   = 2;
    localparam int         HOLD   = 4;
    localparam logic [W-1:0] EDGE_W = 4'b0001;

    logic          aclk        = 1'b0;
    logic          areset      = 1'b1;
    logic [W-1:0]  s_interrupt = '0;
    logic [W-1:0]  irq_enable  = '0;
    logic [W-1:0]  pending;
    logic          irq;
    logic [ID_W-1:0] irq_id;

    interrupt_collector_if #(.W(W)) ack_if();

    interrupt_collector #(
        .C_INTERRUPT_WIDTH (W),
        .C_EDGE_MASK       ({28'h0, EDGE_W}),
        .C_SYNC_STAGES     (SYNC),
        .C_HOLDOFF         (HOLD)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_interrupt (s_interrupt),
        .irq_enable  (irq_enable),
        .ack_if      (ack_if),
        .pending     (pending),
        .irq         (irq),
        .irq_id      (irq_id)
    );

    always #5 aclk = ~aclk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    logic [W-1:0]    m_hist [SYNC];   // m_hist[0] = most recent sample
    logic [W-1:0]    m_prev;
    logic [W-1:0]    m_pending;
    logic            m_irq;
    logic            m_ready;
    logic [ID_W-1:0] m_id;
    bit              m_acc;           // an ack was accepted on the last edge
    int              m_hold;          // cycles of refused acks still to go

    // Predict the effect of the coming edge with the inputs as driven, then
    // advance the clock and return half a period later.
    task automatic step();
        logic [W-1:0]    s, set, act;
        logic [ID_W-1:0] id_n;
        logic            irq_n;
        bit              acc;
        if (areset) begin
            for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
            m_prev = '0; m_pending = '0; m_irq = 1'b0; m_ready = 1'b0;
            m_id = '0; m_acc = 1'b0; m_hold = 0;
        end else begin
            s   = m_hist[SYNC-1];
            set = (s & ~m_prev & EDGE_W) | (s & ~EDGE_W);
            act = m_pending & irq_enable;
            acc = ack_if.ack_valid && m_ready;
            id_n = '0;
            for (int i = 0; i < W; i++) begin
                if (act[i]) begin id_n = ID_W'(i); break; end
            end
            if (m_hold > 0) begin
                m_hold = m_hold - 1;
                irq_n  = 1'b0;
            end else if (m_irq && acc) begin
                m_hold = HOLD;
                irq_n  = 1'b0;
            end else begin
                irq_n = (act != '0);
            end
            m_pending = acc ? ((m_pending & ~ack_if.ack_mask) | set) : (m_pending | set);
            m_irq   = irq_n;
            m_id    = id_n;
            m_ready = (m_hold == 0);
            m_acc   = acc;
            m_prev  = s;
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = s_interrupt;
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        areset = 1'b1; s_interrupt = '0; irq_enable = '0;
        ack_if.ack_valid = 1'b0; ack_if.ack_mask = '0;
        step(); step();
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL reset_pending: got %b required 0000", pending); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b required 0", irq); end
        vectors++; if (irq_id !== 2'd0) begin miscompares++; $display("FAIL reset_id: got %0d required 0", irq_id); end
        vectors++; if (ack_if.ack_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_reset: got %b required 0", ack_if.ack_ready); end
        areset = 1'b0;
        step();
        vectors++; if (ack_if.ack_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b required 1", ack_if.ack_ready); end
        vectors++; if ({pending, irq} !== 5'b0) begin miscompares++; $display("FAIL reset_idle: got pending=%b irq=%b required 0000/0", pending, irq); end
        $display("[tb] test_reset done");
    endtask

    task automatic test_edge();
        irq_enable = 4'hF;
        s_interrupt = 4'b0001; step();            // edge k samples the pulse
        s_interrupt = 4'b0000; step();            // edge k+1
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL edge_early: got %b required 0000", pending); end
        step();                                   // edge k+2
        vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL edge_pending: got %b required 0001", pending); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL edge_irq_early: got %b required 0", irq); end
        step();                                   // edge k+3
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd0) begin miscompares++; $display("FAIL edge_irq: got irq=%b id=%0d required 1/0", irq, irq_id); end
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'b0001;
        step();
        ack_if.ack_valid = 1'b0;
        vectors++; if ({pending, irq, ack_if.ack_ready} !== 6'b0) begin miscompares++; $display("FAIL edge_ack: got pending=%b irq=%b ready=%b required 0000/0/0", pending, irq, ack_if.ack_ready); end
        for (int n = 0; n < HOLD - 1; n++) begin
            step();
            vectors++; if (ack_if.ack_ready !== 1'b0) begin miscompares++; $display("FAIL edge_holdoff_ready cyc %0d: got %b required 0", n, ack_if.ack_ready); end
        end
        step();
        vectors++; if (ack_if.ack_ready !== 1'b1) begin miscompares++; $display("FAIL edge_holdoff_end: got %b required 1", ack_if.ack_ready); end
        $display("[tb] test_edge done");
    endtask

    task automatic test_level_holdoff();
        s_interrupt = 4'b0100;
        for (int n = 0; n < 12 && irq !== 1'b1; n++) step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b0100) begin miscompares++; $display("FAIL level_raise: got irq=%b id=%0d pending=%b required 1/2/0100", irq, irq_id, pending); end
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'b0100;
        step();
        ack_if.ack_valid = 1'b0;
        vectors++; if (pending !== 4'b0100 || irq !== 1'b0) begin miscompares++; $display("FAIL level_resets: got pending=%b irq=%b required 0100/0", pending, irq); end
        step(); step(); step(); step();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL level_holdoff_low: got %b required 0", irq); end
        step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd2) begin miscompares++; $display("FAIL level_reassert: got irq=%b id=%0d required 1/2", irq, irq_id); end
        s_interrupt = 4'b0000;
        step(); step(); step();
        vectors++; if (pending !== 4'b0100) begin miscompares++; $display("FAIL level_sticky: got %b required 0100", pending); end
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'b0100;
        step();
        ack_if.ack_valid = 1'b0;
        vectors++; if (pending !== 4'b0000 || irq !== 1'b0) begin miscompares++; $display("FAIL level_clear: got pending=%b irq=%b required 0000/0", pending, irq); end
        for (int n = 0; n < 6; n++) step();
        vectors++; if (irq !== 1'b0 || ack_if.ack_ready !== 1'b1) begin miscompares++; $display("FAIL level_quiet: got irq=%b ready=%b required 0/1", irq, ack_if.ack_ready); end
        $display("[tb] test_level_holdoff done");
    endtask

    task automatic test_set_wins();
        s_interrupt = 4'b0001; step();
        s_interrupt = 4'b0000;
        for (int n = 0; n < 12 && irq !== 1'b1; n++) step();
        vectors++; if (irq !== 1'b1 || pending !== 4'b0001) begin miscompares++; $display("FAIL setwins_prep: got irq=%b pending=%b required 1/0001", irq, pending); end
        s_interrupt = 4'b0001; step();            // edge m
        s_interrupt = 4'b0000; step();            // edge m+1
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'b0001;
        step();                                   // edge m+2: set and clear collide
        ack_if.ack_valid = 1'b0;
        vectors++; if (pending !== 4'b0001 || ack_if.ack_ready !== 1'b0) begin miscompares++; $display("FAIL setwins: got pending=%b ready=%b required 0001/0", pending, ack_if.ack_ready); end
        for (int n = 0; n < 6; n++) step();
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'hF;
        step();
        ack_if.ack_valid = 1'b0;
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL setwins_cleanup: got %b required 0000", pending); end
        for (int n = 0; n < 6; n++) step();
        $display("[tb] test_set_wins done");
    endtask

    task automatic test_enable_drop();
        irq_enable = 4'b0010;
        s_interrupt = 4'b1010; step();
        s_interrupt = 4'b0000;
        for (int n = 0; n < 5; n++) step();
        vectors++; if (pending !== 4'b1010 || irq !== 1'b1 || irq_id !== 2'd1) begin miscompares++; $display("FAIL en_masked: got pending=%b irq=%b id=%0d required 1010/1/1", pending, irq, irq_id); end
        irq_enable = 4'b0000;
        step();
        vectors++; if (pending !== 4'b1010 || irq !== 1'b0 || irq_id !== 2'd0) begin miscompares++; $display("FAIL en_drop: got pending=%b irq=%b id=%0d required 1010/0/0", pending, irq, irq_id); end
        irq_enable = 4'hF;
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'hF;
        step();
        ack_if.ack_valid = 1'b0;
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL en_poll_clear: got %b required 0000", pending); end
        for (int n = 0; n < 8; n++) step();
        $display("[tb] test_enable_drop done");
    endtask

    task automatic test_reset_mid();
        s_interrupt = 4'b0101;
        for (int n = 0; n < 12 && irq !== 1'b1; n++) step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd0) begin miscompares++; $display("FAIL rst_prep: got irq=%b id=%0d required 1/0", irq, irq_id); end
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'b0101;
        step();
        ack_if.ack_valid = 1'b0;
        vectors++; if (pending !== 4'b0100) begin miscompares++; $display("FAIL rst_held_edge: got %b required 0100", pending); end
        step();
        areset = 1'b1;
        step();
        vectors++; if ({pending, irq, irq_id, ack_if.ack_ready} !== 8'b0) begin miscompares++; $display("FAIL rst_mid: got pending=%b irq=%b id=%0d ready=%b required all 0", pending, irq, irq_id, ack_if.ack_ready); end
        areset = 1'b0;
        step(); step();
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL rst_refill_early: got %b required 0000", pending); end
        step();
        vectors++; if (pending !== 4'b0101) begin miscompares++; $display("FAIL rst_refill: got %b required 0101", pending); end
        s_interrupt = 4'b0000;
        for (int n = 0; n < 8; n++) step();
        ack_if.ack_valid = 1'b1; ack_if.ack_mask = 4'hF;
        for (int n = 0; n < 8 && !m_acc; n++) step();
        ack_if.ack_valid = 1'b0;
        for (int n = 0; n < 8; n++) step();
        $display("[tb] test_reset_mid done");
    endtask

    task automatic test_random(input int cycles);
        areset = 1'b1; step(); areset = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            areset = ($urandom_range(63) == 0);
            // A pending ack is held unchanged until the handshake completes.
            if (!ack_if.ack_valid || m_acc) begin
                ack_if.ack_valid = ($urandom_range(3) == 0);
                ack_if.ack_mask  = W'($urandom);
            end
            s_interrupt = s_interrupt ^ (W'($urandom) & W'($urandom));
            if ($urandom_range(7) == 0) irq_enable = W'($urandom);
            step();
            vectors++;
            if ({pending, irq, irq_id, ack_if.ack_ready} !== {m_pending, m_irq, m_id, m_ready}) begin
                miscompares++;
                $display("FAIL random cyc %0d: got pending=%b irq=%b id=%0d ready=%b required pending=%b irq=%b id=%0d ready=%b",
                         c, pending, irq, irq_id, ack_if.ack_ready, m_pending, m_irq, m_id, m_ready);
            end
        end
        $display("[tb] test_random done (%0d cycles)", cycles);
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level_holdoff();
        test_set_wins();
        test_enable_drop();
        test_reset_mid();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/interrupt_collector.md
Name: interrupt_collector

Overview:
Receiving end of the interrupt_rtl interface. It consumes a bundle of interrupt lines from an upstream interrupt wirethrough and latches them into sticky pending bits, edge- or level-sensitive per bit. It applies a per-bit enable mask and drives a single aggregated, registered irq with a lowest-index ID. Software or a host agent clears pending bits through a valid/ready acknowledge handshake; a hold-off counter prevents immediate re-assertion while a level source deasserts.

Parameters:
C_INTERRUPT_WIDTH, 1, number of interrupt lines; range 1..32.
C_EDGE_MASK, 0, bit i = 1 makes line i rising-edge sensitive; 0 makes it level sensitive.
C_SYNC_STAGES, 2, synchronizer flops per input line; 0 = input already in aclk domain.
C_HOLDOFF, 4, irq forced-low cycles after each accepted ack; range 0..255.

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
s_interrupt  in  C_INTERRUPT_WIDTH  interrupt_rtl S_INTERRUPT lines
irq_enable  in  C_INTERRUPT_WIDTH  per-bit enable for irq aggregation
ack_valid  in  1  acknowledge request
ack_mask  in  C_INTERRUPT_WIDTH  pending bits to clear; sampled on handshake
ack_ready  out  1  collector can accept ack
pending  out  C_INTERRUPT_WIDTH  sticky pending status, registered
irq  out  1  aggregated interrupt, registered
irq_id  out  max(1,clog2(C_INTERRUPT_WIDTH))  lowest index set in pending&irq_enable; 0 when none

Behaviour:
- Reset: areset sampled high clears all of the following to 0: sync flops, edge-history, pending, irq, irq_id, ack_ready, holdoff counter; FSM goes to IDLE. ack_ready is 1 from the first cycle after areset is low.
- Reset mid-operation: all pending bits are lost and an in-flight ack is dropped. Edge-history resets to 0, so a line held high across reset re-fires in edge mode.
- Sync: s_sync = s_interrupt delayed C_SYNC_STAGES cycles (combinational when 0).
- Set condition, edge line: s_sync & ~s_prev, where s_prev is s_sync from the previous cycle.
- Set condition, level line: s_sync == 1.
- Set is independent of irq_enable; pending always records the event.
- Pending latency: with the input high before edge k, pending is visible after edge k+C_SYNC_STAGES.
- Handshake: an ack transfers on a cycle with ack_valid & ack_ready. On that edge, pending <= (pending & ~ack_mask) | set.
  - Set and clear on the same bit in the same cycle: set wins; no event is lost.
  - Level line still high after its ack: pending re-sets on the same edge.
  - ack_mask == 0: a legal no-op handshake that still starts the hold-off.
- ack_ready deasserts only in reset and during HOLDOFF. ack_valid arriving during HOLDOFF waits; the master holds ack_valid and ack_mask stable until accepted.
- Active set: act = pending & irq_enable.
- FSM IDLE (irq=0): go to ASSERT when act != 0; irq rises one cycle after act becomes nonzero.
- FSM ASSERT (irq=1): on an accepted ack, go to HOLDOFF with cnt = C_HOLDOFF, or straight to IDLE when C_HOLDOFF = 0. If act becomes 0 via an enable drop, go to IDLE with irq low the next cycle.
- FSM HOLDOFF (irq=0, ack_ready=0): cnt decrements each cycle; at cnt == 1 go to IDLE. IDLE then re-raises irq if act is still nonzero.
- Ack in IDLE (polling mode): accepted and clears bits; no hold-off is started.
- irq_id is registered in parallel with irq; it updates every cycle in all states; priority is the lowest index.
- Width rule: C_INTERRUPT_WIDTH == 1 gives irq_id a 1-bit constant 0.

Decomposition:
- Shared package intr_pkg:
  - FSM state enum {IDLE, ASSERT, HOLDOFF}.
  - Function id_width(w) = max(1,clog2(w)).
  - Constant C_MAX_HOLDOFF = 255.
- One sub-module, intr_sync_edge: per-line synchronizer plus edge/level set generation, instantiated per bit with a generate loop.
- The FSM, pending register and priority encoder stay in the top module.

Test Plan:
- Reset, then s_interrupt=0: pending=0, irq=0, irq_id=0, ack_ready=1 one cycle after release.
- W=4, EDGE_MASK=4'b0001, SYNC=2, enable=4'hF. Pulse bit0 for 1 cycle at edge 10 -> pending=4'b0001 after edge 12, irq=1 after edge 13, irq_id=0. Ack mask 4'b0001 -> pending=0, irq=0, ack_ready=0 for 4 cycles.
- Level bit2 held high and acked -> pending[2] stays 1. After HOLDOFF=4 cycles irq re-asserts with irq_id=2. Drop the line, ack again -> pending=0, irq stays 0.
- Edge on bit0 in the same cycle as an ack clearing bit0 -> pending[0] remains 1 (set wins).
- pending=4'b1010, enable=4'b0010 -> irq=1, irq_id=1. Set enable=0 -> irq=0 next cycle, pending unchanged.
- areset asserted during HOLDOFF with pending=4'b0100 -> all outputs 0 next cycle. If the level line is still high, pending[2] returns C_SYNC_STAGES cycles after release.
